// File: rtl/pipeline_sub_hs.sv
// Pipelined unsigned subtractor with valid/ready flow control, per-stage
// backpressure, bubble collapsing, synchronous flush and an occupancy count.
module pipeline_sub_hs #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             minuend,
   input  logic [WIDTH-1:0]             subtrahend,
   input  logic                         flush,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             diff,
   output logic                         borrow,
   output logic [$clog2(STAGES+1)-1:0]  occupancy
);

   localparam int unsigned S     = STAGES;
   localparam int          OCC_W = $clog2(STAGES+1);

   logic [STAGES-1:0]             v;
   logic [STAGES-1:0]             v_next;
   logic [STAGES-1:0]             adv;
   logic [STAGES-1:0][WIDTH-1:0]  d;
   logic [STAGES-1:0]             b;
   logic [OCC_W-1:0]              occ_next;
   logic [WIDTH:0]                sub_full;
   logic                          take;
   logic                          room;

   // A stage may advance when some stage below it (towards the output) is
   // empty, or the whole tail is full and the consumer is taking a result.
   always_comb begin
      adv  = '0;
      room = out_ready;
      for (int unsigned i = 0; i < S; i++) begin
         adv[S-1-i] = v[S-1-i] & room;
         room       = ~v[S-1-i] | room;
      end
   end

   assign in_ready = ~flush & (~v[0] | adv[0]);
   assign take     = in_valid & in_ready;
   assign sub_full = {1'b0, minuend} - {1'b0, subtrahend};

   always_comb begin
      v_next    = '0;
      v_next[0] = take | (v[0] & ~adv[0]);
      for (int unsigned i = 1; i < S; i++) begin
         v_next[i] = adv[i-1] | (v[i] & ~adv[i]);
      end
   end

   always_comb begin
      occ_next = '0;
      for (int unsigned i = 0; i < S; i++) begin
         occ_next = occ_next + OCC_W'(v_next[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v         <= '0;
         d         <= '0;
         b         <= '0;
         occupancy <= '0;
      end else begin
         v         <= flush ? '0 : v_next;
         occupancy <= flush ? '0 : occ_next;
         if (take) begin
            d[0] <= sub_full[WIDTH-1:0];
            b[0] <= sub_full[WIDTH];
         end
         for (int unsigned i = 1; i < S; i++) begin
            if (adv[i-1]) begin
               d[i] <= d[i-1];
               b[i] <= b[i-1];
            end
         end
      end
   end

   assign out_valid = v[S-1];
   assign diff      = d[S-1];
   assign borrow    = b[S-1];

endmodule

// File: tb/tb_pipeline_sub_hs.sv
// Scoreboard bench for pipeline_sub_hs: accepted pairs are queued with their
// acceptance edge; a monitor checks timing, flow control and results.
module tb_pipeline_sub_hs;

   localparam int W     = 32;
   localparam int S     = 4;
   localparam int OCC_W = $clog2(S+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [W-1:0]     minuend;
   logic [W-1:0]     subtrahend;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [W-1:0]     diff;
   logic             borrow;
   logic [OCC_W-1:0] occupancy;

   pipeline_sub_hs #(.WIDTH(W), .STAGES(S)) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .minuend    (minuend),
      .subtrahend (subtrahend),
      .flush      (flush),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow     (borrow),
      .occupancy  (occupancy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] d;
      logic         b;
      int           t;
   } item_t;

   item_t q[$];
   int    cyc     = 0;
   int    errors  = 0;
   int    checks  = 0;
   bit    started = 0;
   int    idx;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) cyc++;

   // Monitor: pipe contents equal the queue; the head is at the output once
   // it has aged STAGES-1 edges, since nothing ahead of it can block it.
   always @(negedge clk) begin
      if (started && !rst) begin
         chk("occupancy", 64'(occupancy), 64'(q.size()));
         chk("in_ready", 64'(in_ready), 64'(!flush && !(q.size() == S && !out_ready)));
         chk("out_valid", 64'(out_valid), 64'(q.size() > 0 && (cyc - q[0].t) >= S-1));
         if (out_valid && q.size() > 0) begin
            chk("diff", 64'(diff), 64'(q[0].d));
            chk("borrow", 64'(borrow), 64'(q[0].b));
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   // Acceptance sampler: runs after the monitor so flush discards only what
   // was not handed to the consumer this cycle.
   always @(negedge clk) begin
      #1;
      if (started && !rst) begin
         if (flush) q.delete();
         if (in_valid && in_ready) begin
            item_t it;
            it.d = minuend - subtrahend;
            it.b = (minuend < subtrahend);
            it.t = cyc + 1;
            q.push_back(it);
         end
      end
   end

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] bb);
      int n;
      minuend = a; subtrahend = bb; in_valid = 1'b1;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         checks++; errors++;
         $display("FAIL send_timeout actual=in_ready_low required=accept");
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      out_ready = 1'b1;
      n = 0;
      while (q.size() != 0 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain_timeout actual=%0d required=0 items left", q.size());
      end
      @(posedge clk); #1;
   endtask

   function automatic logic [W-1:0] pick();
      case ($urandom_range(0, 5))
         0:       return '0;
         1:       return '1;
         2:       return W'($urandom_range(0, 3));
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
      minuend = '0; subtrahend = '0;
      #1;
      chk("reset_out_valid", 64'(out_valid), 64'd0);
      chk("reset_occupancy", 64'(occupancy), 64'd0);
      chk("reset_diff", 64'(diff), 64'd0);
      chk("reset_borrow", 64'(borrow), 64'd0);
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;
      started = 1;
      @(negedge clk);
      chk("idle_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;

      // basic and borrow / wrap cases
      send(15, 10); drain();
      send(50, 30); drain();
      send(10, 15); send(0, 0); send(32'hFFFF_FFFF, 1); send(5, 5); drain();

      // back-to-back streaming
      for (int i = 0; i < 8; i++) send(W'(100 + i), W'(i));
      drain();

      // backpressure: exactly STAGES accepted while stalled
      out_ready = 1'b0;
      idx = 0;
      for (int c = 0; c < 8; c++) begin
         minuend = W'(200 + 3*idx); subtrahend = W'(idx); in_valid = 1'b1;
         @(negedge clk);
         if (in_ready) idx++;
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
      chk("bp_accepted", 64'(idx), 64'(S));
      chk("bp_occupancy", 64'(occupancy), 64'(S));
      out_ready = 1'b1;
      for (; idx < 6; idx++) send(W'(200 + 3*idx), W'(idx));
      drain();

      // flush with a pending input
      out_ready = 1'b0;
      send(21, 1); send(22, 2); send(23, 3);
      flush = 1'b1; in_valid = 1'b1; minuend = 99; subtrahend = 9;
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      flush = 1'b0; in_valid = 1'b0;
      @(negedge clk);
      chk("flush_occupancy", 64'(occupancy), 64'd0);
      chk("flush_out_valid", 64'(out_valid), 64'd0);
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(9, 4); drain();

      // asynchronous reset mid-flight
      out_ready = 1'b0;
      send(1, 2); send(3, 4);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      chk("async_rst_out_valid", 64'(out_valid), 64'd0);
      chk("async_rst_occupancy", 64'(occupancy), 64'd0);
      q.delete();
      @(posedge clk); #1;
      rst = 1'b0; out_ready = 1'b1;
      send(7, 3); drain();

      // randomized traffic with stalls and occasional flush
      for (int c = 0; c < 800; c++) begin
         in_valid   = 1'($urandom_range(0, 1));
         minuend    = pick();
         subtrahend = pick();
         out_ready  = ($urandom_range(0, 3) != 0);
         flush      = ($urandom_range(0, 40) == 0);
         @(posedge clk); #1;
      end
      in_valid = 1'b0; flush = 1'b0;
      drain();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
